spi_slave_regif: RTL and testbench
==================================

Name: spi_slave_regif

Overview:
- SPI slave endpoint that sits directly downstream of apb_spi_master, on its spi_clk/spi_csn0/spi_sdo0/spi_sdi0 pins.
- Decodes single-lane mode-0 frames (command, address, data) into single-word register-bus reads and writes.
- Returns read data on the serial line.
- Oversamples SPI pins in the system clock domain, so no SPI-clocked flops exist.

Parameters:
- ADDR_WIDTH, 8, register address bits in the frame and on reg_addr_o.
- DATA_WIDTH, 32, data bits per frame and register width.
- DUMMY_BITS, 8, SCLK cycles between address and read data (must be >= 1).
- SYNC_STAGES, 2, synchronizer depth for sclk/csn/sdi (>= 2).

Ports:
- clk_i  in  1  system clock; requirement: SPI SCLK period >= 8 clk_i periods.
- rst_ni  in  1  reset, asynchronous, active-low.
- spi_sclk_i  in  1  SPI clock, CPOL=0.
- spi_csn_i  in  1  chip select, active-low.
- spi_sdi_i  in  1  MOSI.
- spi_sdo_o  out  1  MISO.
- spi_sdo_oe_o  out  1  MISO output enable.
- reg_req_o  out  1  register request valid.
- reg_we_o  out  1  1=write, 0=read.
- reg_addr_o  out  ADDR_WIDTH  register address.
- reg_wdata_o  out  DATA_WIDTH  write data.
- reg_gnt_i  in  1  request accepted.
- reg_rvalid_i  in  1  read data valid, one pulse.
- reg_rdata_i  in  DATA_WIDTH  read data.
- err_o  out  1  one-cycle pulse on protocol error.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters and shift registers 0. Reset is asynchronous; deassertion is used as-is.
- Input synchronization: sclk, csn and sdi pass through SYNC_STAGES flops.
  - rise = sclk_s & ~sclk_q; fall = ~sclk_s & sclk_q.
  - csn_s falling = frame start; csn_s rising = frame end.
- Sampling rules (mode 0): sdi sampled on rise, MSB first; sdo updated on fall.
- FSM states:
  - IDLE: on frame start -> CMD, bit counter = 0.
  - CMD: after 8 rises, latch cmd.
    - 0x02 -> ADDR (write).
    - 0x03 -> ADDR (read).
    - Any other value -> IGNORE, err_o pulse.
  - ADDR: after ADDR_WIDTH rises, latch address.
    - Write -> WDATA.
    - Read -> RDUMMY; assert reg_req_o with reg_we_o=0 the same cycle.
  - WDATA: after DATA_WIDTH rises -> WREQ with reg_req_o=1, reg_we_o=1.
  - WREQ: hold req/addr/wdata stable until reg_gnt_i, then -> IGNORE (or IDLE if csn already high). The write completes even if csn rises first.
  - RDUMMY:
    - req is held until gnt; rdata is captured on reg_rvalid_i.
    - The read response may arrive before the request is granted; capture it anyway.
    - After DUMMY_BITS rises -> RDATA. On the fall following the last dummy rise, drive the data MSB.
    - If rdata has not been captured by the last dummy rise: shift out 0xDEADBEEF (truncated/zero-extended to DATA_WIDTH) and pulse err_o.
  - RDATA:
    - spi_sdo_oe_o=1; shift the next bit on each fall.
    - After DATA_WIDTH rises -> IGNORE, sdo_oe=0.
  - IGNORE: discard edges until frame end -> IDLE.
- Frame end (csn rise) in CMD, ADDR, WDATA, RDUMMY or RDATA:
  - Abort to IDLE, sdo_oe=0.
  - Pulse err_o if the frame is incomplete (CMD/ADDR/WDATA partial, or RDATA before the final bit).
  - An outstanding read req is still held until gnt, and its rvalid is consumed and discarded.
  - No write is issued.
- Ordering: a new frame start while a request is pending is held in IDLE until gnt. Master timing guarantees this never overlaps more than DUMMY_BITS SCLKs.
- Outputs: spi_sdo_o=0 whenever oe=0. reg_wdata_o and reg_addr_o change only when req is low.
- Bit counter: 6 bits, saturates; it is cleared on every state change.

Decomposition:
- Package spi_slave_pkg:
  - state enum spi_slv_state_e.
  - constants CMD_WRITE=8'h02, CMD_READ=8'h03, RD_ERR_PATTERN=32'hDEADBEEF.
- Sub-module spi_slave_sync: parameterised multi-stage synchronizer plus edge detector, instantiated per pin (edge outputs used for sclk and csn).

Test Plan:
- Write frame 0x02, addr 0x10, data 0xA5A5_1234; gnt after 3 cycles -> one req with we=1, addr=0x10, wdata=0xA5A51234, held until gnt; err_o never asserted.
- Read frame 0x03, addr 0x24, rvalid 2 cycles after gnt with 0xCAFE_F00D -> req we=0 asserted after the address bit; MISO shows 0xCAFEF00D MSB-first after 8 dummy clocks.
- Read with rvalid delayed beyond the dummy phase -> MISO shows 0xDEADBEEF; err_o pulses once; the late rvalid is discarded with no lockup.
- Command 0x9F -> err_o pulse after the 8th rise; no req; the rest of the frame is ignored; the next valid frame works.
- csn raised after 20 of 32 write-data bits -> no req, err_o pulse, FSM returns to IDLE; the next write frame completes correctly.
- Reset asserted mid-RDATA -> all outputs 0 immediately (asynchronous); after release, a fresh read frame returns the correct data.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared types and constants for the SPI slave register bridge.
// Holds the FSM state enum, frame command codes and the read-miss fill word.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_WREQ,
    ST_RDUMMY,
    ST_RDATA,
    ST_IGNORE
  } spi_slv_state_e;

  localparam logic [7:0]  CMD_WRITE      = 8'h02;
  localparam logic [7:0]  CMD_READ       = 8'h03;
  localparam logic [31:0] RD_ERR_PATTERN = 32'hDEADBEEF;

  localparam int CNT_W = 6;

endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: multi-flop synchronizer for one SPI pin plus edge detect.
// Ports: clk_i/rst_ni, d_i async pin; q_o synced level, rise_o/fall_o pulses.
module spi_slave_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] r_sync;
  logic              r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= {STAGES{RST_VAL}};
      r_q    <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_i};
      r_q    <= r_sync[STAGES-1];
    end
  end

  assign q_o    = r_sync[STAGES-1];
  assign rise_o = q_o & ~r_q;
  assign fall_o = ~q_o & r_q;

endmodule

// File: rtl/spi_slave_regif.sv
// spi_slave_regif: mode-0 SPI slave decoding cmd/addr/data frames into a
// single-word register bus. Ports: clk_i, rst_ni; spi_sclk_i, spi_csn_i,
// spi_sdi_i, spi_sdo_o, spi_sdo_oe_o; reg_req_o, reg_we_o, reg_addr_o,
// reg_wdata_o, reg_gnt_i, reg_rvalid_i, reg_rdata_i; err_o error pulse.
module spi_slave_regif
  import spi_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DUMMY_BITS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  spi_sclk_i,
  input  logic                  spi_csn_i,
  input  logic                  spi_sdi_i,
  output logic                  spi_sdo_o,
  output logic                  spi_sdo_oe_o,
  output logic                  reg_req_o,
  output logic                  reg_we_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  input  logic                  reg_gnt_i,
  input  logic                  reg_rvalid_i,
  input  logic [DATA_WIDTH-1:0] reg_rdata_i,
  output logic                  err_o
);

  localparam logic [CNT_W-1:0] LAST_CMD   = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_DUMMY = CNT_W'(DUMMY_BITS - 1);

  localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(RD_ERR_PATTERN);

  logic w_sclk_lvl;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_csn;
  logic w_csn_rise;
  logic w_csn_fall;
  logic w_sdi;
  logic w_sdi_rise;
  logic w_sdi_fall;
  logic w_unused;

  spi_slave_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sync_sclk (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (spi_sclk_i),
    .q_o   (w_sclk_lvl),
    .rise_o(w_sclk_rise),
    .fall_o(w_sclk_fall)
  );

  // csn idles high, so its flops reset high to avoid a fake frame start.
  spi_slave_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sync_csn (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (spi_csn_i),
    .q_o   (w_csn),
    .rise_o(w_csn_rise),
    .fall_o(w_csn_fall)
  );

  spi_slave_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sync_sdi (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (spi_sdi_i),
    .q_o   (w_sdi),
    .rise_o(w_sdi_rise),
    .fall_o(w_sdi_fall)
  );

  assign w_unused = ^{w_sclk_lvl, w_csn_fall, w_sdi_rise, w_sdi_fall};

  spi_slv_state_e r_state;
  spi_slv_state_e w_state_nx;

  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-2:0] r_sh;
  logic [DATA_WIDTH-1:0] w_sh_nx;
  logic [7:0]            w_cmd;
  logic                  r_rd;

  logic                  r_req;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  r_pend;
  logic                  r_stale;
  logic                  r_rvld;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [DATA_WIDTH-1:0] r_sdo_sh;
  logic                  r_sdo;
  logic                  r_oe;
  logic                  r_err;

  logic w_err;
  logic w_lat_cmd;
  logic w_lat_addr;
  logic w_issue_wr;
  logic w_issue_rd;
  logic w_load_sdo;
  logic w_kill_rd;
  logic w_rv_take;

  assign w_sh_nx = {r_sh, w_sdi};
  assign w_cmd   = w_sh_nx[7:0];

  always_comb begin
    w_state_nx = r_state;
    w_err      = 1'b0;
    w_lat_cmd  = 1'b0;
    w_lat_addr = 1'b0;
    w_issue_wr = 1'b0;
    w_issue_rd = 1'b0;
    w_load_sdo = 1'b0;
    w_kill_rd  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Level-based start lets a frame wait here for a pending grant.
        if (!w_csn && !r_req) begin
          w_state_nx = ST_CMD;
        end
      end
      ST_CMD: begin
        if (w_csn_rise) begin
          w_state_nx = ST_IDLE;
          w_err      = 1'b1;
        end else if (w_sclk_rise && r_cnt == LAST_CMD) begin
          w_lat_cmd = 1'b1;
          if (w_cmd == CMD_WRITE || w_cmd == CMD_READ) begin
            w_state_nx = ST_ADDR;
          end else begin
            w_state_nx = ST_IGNORE;
            w_err      = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (w_csn_rise) begin
          w_state_nx = ST_IDLE;
          w_err      = 1'b1;
        end else if (w_sclk_rise && r_cnt == LAST_ADDR) begin
          w_lat_addr = 1'b1;
          if (r_rd) begin
            w_issue_rd = 1'b1;
            w_state_nx = ST_RDUMMY;
          end else begin
            w_state_nx = ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        if (w_csn_rise) begin
          w_state_nx = ST_IDLE;
          w_err      = 1'b1;
        end else if (w_sclk_rise && r_cnt == LAST_DATA) begin
          w_issue_wr = 1'b1;
          w_state_nx = ST_WREQ;
        end
      end
      ST_WREQ: begin
        if (reg_gnt_i) begin
          w_state_nx = w_csn ? ST_IDLE : ST_IGNORE;
        end
      end
      ST_RDUMMY: begin
        if (w_csn_rise) begin
          w_state_nx = ST_IDLE;
          w_err      = 1'b1;
          w_kill_rd  = 1'b1;
        end else if (w_sclk_rise && r_cnt == LAST_DUMMY) begin
          w_load_sdo = 1'b1;
          w_state_nx = ST_RDATA;
          if (!r_rvld) begin
            w_err     = 1'b1;
            w_kill_rd = 1'b1;
          end
        end
      end
      ST_RDATA: begin
        if (w_csn_rise) begin
          w_state_nx = ST_IDLE;
          w_err      = 1'b1;
        end else if (w_sclk_rise && r_cnt == LAST_DATA) begin
          w_state_nx = ST_IGNORE;
        end
      end
      ST_IGNORE: begin
        if (w_csn) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_state_nx != r_state) begin
        r_cnt <= '0;
      end else if (w_sclk_rise && r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // A response arriving while an older abandoned read is still owed
  // belongs to that older read and is dropped.
  assign w_rv_take = reg_rvalid_i && !r_stale && r_pend;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sh    <= '0;
      r_rd    <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_pend  <= 1'b0;
      r_stale <= 1'b0;
      r_rvld  <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_sclk_rise) begin
        r_sh <= w_sh_nx[DATA_WIDTH-2:0];
      end
      if (w_lat_cmd) begin
        r_rd <= (w_cmd == CMD_READ);
      end
      if (w_lat_addr) begin
        r_addr <= w_sh_nx[ADDR_WIDTH-1:0];
      end
      if (r_req && reg_gnt_i) begin
        r_req <= 1'b0;
      end
      if (w_issue_wr) begin
        r_req   <= 1'b1;
        r_we    <= 1'b1;
        r_wdata <= w_sh_nx;
      end
      if (w_issue_rd) begin
        r_req  <= 1'b1;
        r_we   <= 1'b0;
        r_pend <= 1'b1;
        r_rvld <= 1'b0;
      end
      if (reg_rvalid_i) begin
        if (r_stale) begin
          r_stale <= 1'b0;
        end else if (r_pend) begin
          r_rdata <= reg_rdata_i;
          r_rvld  <= 1'b1;
          r_pend  <= 1'b0;
        end
      end
      if (w_kill_rd && r_pend && !w_rv_take) begin
        r_stale <= 1'b1;
        r_pend  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sdo_sh <= '0;
      r_sdo    <= 1'b0;
      r_oe     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_load_sdo) begin
        r_sdo_sh <= r_rvld ? r_rdata : ERR_WORD;
      end else if (r_state == ST_RDATA && w_sclk_fall) begin
        r_sdo_sh <= {r_sdo_sh[DATA_WIDTH-2:0], 1'b0};
      end
      r_oe <= (w_state_nx == ST_RDATA);
      if (w_state_nx != ST_RDATA) begin
        r_sdo <= 1'b0;
      end else if (r_state == ST_RDATA && w_sclk_fall) begin
        r_sdo <= r_sdo_sh[DATA_WIDTH-1];
      end
      r_err <= w_err;
    end
  end

  assign spi_sdo_o    = r_sdo;
  assign spi_sdo_oe_o = r_oe;
  assign reg_req_o    = r_req;
  assign reg_we_o     = r_we;
  assign reg_addr_o   = r_addr;
  assign reg_wdata_o  = r_wdata;
  assign err_o        = r_err;

endmodule

// File: tb/tb_spi_slave_regif.sv
// tb_spi_slave_regif: directed frames through a mode-0 master model, a
// register responder, and a queue-based scoreboard monitor.
module tb_spi_slave_regif;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        csn = 1'b1;
  logic        sdi = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;

  logic        spi_sdo_o;
  logic        spi_sdo_oe_o;
  logic        reg_req_o;
  logic        reg_we_o;
  logic [7:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic        err_o;

  always #5 clk = ~clk;

  spi_slave_regif dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .spi_sclk_i  (sclk),
    .spi_csn_i   (csn),
    .spi_sdi_i   (sdi),
    .spi_sdo_o   (spi_sdo_o),
    .spi_sdo_oe_o(spi_sdo_oe_o),
    .reg_req_o   (reg_req_o),
    .reg_we_o    (reg_we_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_gnt_i   (gnt),
    .reg_rvalid_i(rvalid),
    .reg_rdata_i (rdata),
    .err_o       (err_o)
  );

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_rd[$];
  logic [31:0] got_rd[$];

  int n_tests = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int stab_err = 0;
  int base = 0;

  int          gnt_dly = 1;
  int          rv_dly = 2;
  logic [31:0] rsp_data = '0;
  bit          rsp_busy = 1'b0;
  logic        rsp_we = 1'b0;

  logic        prev_req = 1'b0;
  logic [40:0] prev_bus = '0;
  req_t        cur;
  logic [31:0] cur_rd;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Register bus responder: grant after gnt_dly, read data rv_dly later.
  initial begin
    forever begin
      @(negedge clk);
      if (reg_req_o) begin
        rsp_busy = 1'b1;
        rsp_we = reg_we_o;
        repeat (gnt_dly) @(negedge clk);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        if (!rsp_we) begin
          repeat (rv_dly - 1) @(negedge clk);
          rdata = rsp_data;
          rvalid = 1'b1;
          @(negedge clk);
          rvalid = 1'b0;
        end
        rsp_busy = 1'b0;
      end
    end
  end

  // Monitor: pops expectations as the DUT presents requests and MISO words.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (err_o) err_cnt++;
      if (reg_req_o && prev_req &&
          {reg_we_o, reg_addr_o, reg_wdata_o} != prev_bus) stab_err++;
      prev_req = reg_req_o;
      prev_bus = {reg_we_o, reg_addr_o, reg_wdata_o};
      if (reg_req_o && gnt) begin
        if (exp_req.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL req_unexpected: got we=%b addr=%h, expected none",
                   reg_we_o, reg_addr_o);
        end else begin
          cur = exp_req.pop_front();
          check("req_we", 64'(reg_we_o), 64'(cur.we));
          check("req_addr", 64'(reg_addr_o), 64'(cur.addr));
          if (cur.we) check("req_wdata", 64'(reg_wdata_o), 64'(cur.wdata));
        end
      end
      if (got_rd.size() > 0) begin
        cur_rd = got_rd.pop_front();
        if (exp_rd.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL miso_unexpected: got %h, expected none", cur_rd);
        end else begin
          check("miso_word", 64'(cur_rd), 64'(exp_rd.pop_front()));
        end
      end
    end
  end

  task automatic xfer(input logic b, output logic so);
    sdi = b;
    #(HALF);
    sclk = 1'b1;
    so = spi_sdo_o;
    #(HALF);
    sclk = 1'b0;
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [7:0] addr,
                       input logic [31:0] data, input int ndata,
                       input bit rd, input int rst_at);
    logic        so;
    logic [31:0] rx;
    bit          cut;
    rx = '0;
    cut = 1'b0;
    @(negedge clk);
    csn = 1'b0;
    #(HALF);
    for (int i = 7; i >= 0; i--) xfer(cmd[i], so);
    for (int i = 7; i >= 0; i--) xfer(addr[i], so);
    if (rd) begin
      for (int i = 0; i < 8; i++) xfer(1'b0, so);
      for (int i = 0; i < 32 && !cut; i++) begin
        if (i == rst_at) begin
          check("oe_in_rdata", 64'(spi_sdo_oe_o), 64'd1);
          rst_n = 1'b0;
          #1;
          check("rst_async_outs",
                64'({spi_sdo_o, spi_sdo_oe_o, reg_req_o, reg_we_o, err_o,
                     reg_addr_o, reg_wdata_o}), 64'd0);
          #(HALF - 1);
          csn = 1'b1;
          #(HALF);
          rst_n = 1'b1;
          cut = 1'b1;
        end else begin
          xfer(1'b0, so);
          rx = {rx[30:0], so};
        end
      end
      if (!cut) got_rd.push_back(rx);
    end else begin
      for (int i = 0; i < ndata; i++) xfer(data[31-i], so);
    end
    #(HALF);
    csn = 1'b1;
    #(4 * HALF);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (rsp_busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("resp_idle", 64'(rsp_busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outs",
          64'({spi_sdo_o, spi_sdo_oe_o, reg_req_o, reg_we_o, err_o,
               reg_addr_o, reg_wdata_o}), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    gnt_dly = 3;
    base = err_cnt;
    exp_req.push_back('{we: 1'b1, addr: 8'h10, wdata: 32'hA5A51234});
    frame(8'h02, 8'h10, 32'hA5A51234, 32, 1'b0, -1);
    wait_idle();
    check("err_write", 64'(err_cnt - base), 64'd0);

    gnt_dly = 1;
    rv_dly = 2;
    rsp_data = 32'hCAFEF00D;
    base = err_cnt;
    exp_req.push_back('{we: 1'b0, addr: 8'h24, wdata: 32'h0});
    exp_rd.push_back(32'hCAFEF00D);
    frame(8'h03, 8'h24, 32'h0, 0, 1'b1, -1);
    wait_idle();
    check("err_read", 64'(err_cnt - base), 64'd0);

    rv_dly = 300;
    rsp_data = 32'h11112222;
    base = err_cnt;
    exp_req.push_back('{we: 1'b0, addr: 8'h30, wdata: 32'h0});
    exp_rd.push_back(32'hDEADBEEF);
    frame(8'h03, 8'h30, 32'h0, 0, 1'b1, -1);
    wait_idle();
    check("err_late_read", 64'(err_cnt - base), 64'd1);

    base = err_cnt;
    frame(8'h9F, 8'h55, 32'hFFFFFFFF, 32, 1'b0, -1);
    wait_idle();
    check("err_bad_cmd", 64'(err_cnt - base), 64'd1);

    rv_dly = 2;
    rsp_data = 32'h12345678;
    base = err_cnt;
    exp_req.push_back('{we: 1'b0, addr: 8'h55, wdata: 32'h0});
    exp_rd.push_back(32'h12345678);
    frame(8'h03, 8'h55, 32'h0, 0, 1'b1, -1);
    wait_idle();
    check("err_read_after_bad", 64'(err_cnt - base), 64'd0);

    base = err_cnt;
    frame(8'h02, 8'h40, 32'h89ABCDEF, 20, 1'b0, -1);
    wait_idle();
    check("err_short_write", 64'(err_cnt - base), 64'd1);

    gnt_dly = 2;
    base = err_cnt;
    exp_req.push_back('{we: 1'b1, addr: 8'h7E, wdata: 32'h0BADF00D});
    frame(8'h02, 8'h7E, 32'h0BADF00D, 32, 1'b0, -1);
    wait_idle();
    check("err_write2", 64'(err_cnt - base), 64'd0);

    gnt_dly = 1;
    rsp_data = 32'h87654321;
    base = err_cnt;
    exp_req.push_back('{we: 1'b0, addr: 8'h24, wdata: 32'h0});
    frame(8'h03, 8'h24, 32'h0, 0, 1'b1, 10);
    wait_idle();
    check("err_mid_reset", 64'(err_cnt - base), 64'd0);

    rsp_data = 32'h600DCAFE;
    base = err_cnt;
    exp_req.push_back('{we: 1'b0, addr: 8'h24, wdata: 32'h0});
    exp_rd.push_back(32'h600DCAFE);
    frame(8'h03, 8'h24, 32'h0, 0, 1'b1, -1);
    wait_idle();
    check("err_fresh_read", 64'(err_cnt - base), 64'd0);

    for (int k = 0; k < 200; k++) begin
      if (exp_req.size() == 0 && exp_rd.size() == 0 && got_rd.size() == 0)
        break;
      @(negedge clk);
    end
    check("queues_drained",
          64'(exp_req.size() + exp_rd.size() + got_rd.size()), 64'd0);
    check("req_stable", 64'(stab_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
